automata_report_collector: RTL and testbench

Back-end of an automata cluster. Samples the per-rule match lines a cluster top module raises while `run` is high and tags each match with the input-symbol offset at which it fired. Serialises multi-rule matches into one report record per cycle and buffers the records in a FIFO. Drains the FIFO to the host or engine over a valid/ready stream. Back-pressures the symbol feeder through `stall`.

---
 rtl/automata_report_pkg.sv | 22 ++
 rtl/automata_report_fifo.sv | 68 ++++++
 rtl/automata_report_collector.sv | 158 +++++++++++++++
 tb/tb_automata_report_collector.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/automata_report_pkg.sv
// Shared types and default constants for the automata report collector.
//   report_rec_t : one report record {rule id, symbol offset} at default widths
//   cap_state_t  : capture FSM state (EMPTY = nothing pending, DRAIN = records pending)
package automata_report_pkg;

    localparam int DEF_NUM_REPORTS = 7;
    localparam int DEF_ID_W        = $clog2(DEF_NUM_REPORTS);
    localparam int DEF_OFFSET_W    = 32;
    localparam int DEF_FIFO_DEPTH  = 16;
    localparam int DROP_W          = 16;

    typedef struct packed {
        logic [DEF_ID_W-1:0]     id;
        logic [DEF_OFFSET_W-1:0] offset;
    } report_rec_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } cap_state_t;

endpackage

// File: rtl/automata_report_fifo.sv
// First-word fall-through FIFO of report records.
//   clk, rst (async, active-high), srst (synchronous flush, highest priority)
//   push/push_data : write request, ignored while full (even with a same-edge pop)
//   pop            : consume head, ignored while empty
//   head           : current head record (valid whenever empty = 0)
//   full, empty    : occupancy flags derived from the internal entry count
module automata_report_fifo
    import automata_report_pkg::*;
#(
    parameter type rec_t = report_rec_t,
    parameter int  DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic srst,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output rec_t head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rec_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign push_ok_s = push & ~full & ~srst;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage array write port; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/automata_report_collector.sv
// Report back-end of an automata cluster: tags match vectors with the symbol
// offset, serialises them one rule id per cycle into a FWFT FIFO and streams
// the records out on a valid/ready interface.
//   clk, reset (async, active-high), clear (synchronous flush)
//   run, match_in             : symbol consumed / per-rule match lines
//   stall                     : feeder must hold run low next cycle
//   report_valid/ready/id/offset : record stream to the host or engine
//   overflow, drop_count      : sticky drop flag and saturating drop counter
module automata_report_collector
    import automata_report_pkg::*;
#(
    parameter int NUM_REPORTS = DEF_NUM_REPORTS,
    parameter int ID_W        = $clog2(NUM_REPORTS),
    parameter int OFFSET_W    = DEF_OFFSET_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   run,
    input  logic [NUM_REPORTS-1:0] match_in,
    output logic                   stall,
    output logic                   report_valid,
    input  logic                   report_ready,
    output logic [ID_W-1:0]        report_id,
    output logic [OFFSET_W-1:0]    report_offset,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [OFFSET_W-1:0] offset;
    } rec_t;

    // Index of the lowest set bit; rules drain in ascending id order
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_REPORTS-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_REPORTS-1:0] vec);
        return (vec != '0) && ((vec & (vec - NUM_REPORTS'(1))) == '0);
    endfunction

    cap_state_t             state_r;
    logic [NUM_REPORTS-1:0] pending_r;
    logic [NUM_REPORTS-1:0] pending_next_s;
    logic [OFFSET_W-1:0]    offset_r;
    logic [OFFSET_W-1:0]    cap_offset_r;
    logic                   overflow_r;
    logic [DROP_W-1:0]      drop_count_r;
    logic                   onehot_s;
    logic                   hit_s;
    logic                   accept_s;
    logic                   drain_push_s;
    logic                   load_s;
    logic                   drop_s;
    logic                   push_s;
    rec_t                   push_data_s;
    rec_t                   head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;

    // Load/drain/drop qualification from the current capture state
    always_comb begin
        onehot_s = is_onehot(pending_r);
        hit_s    = run & (|match_in);
        if (state_r == DRAIN) begin
            drain_push_s = ~fifo_full_s;
            // A new vector fits only if the last pending bit leaves on this edge
            accept_s     = onehot_s & ~fifo_full_s;
        end else begin
            drain_push_s = 1'b0;
            accept_s     = 1'b1;
        end
        load_s = hit_s & accept_s;
        drop_s = hit_s & ~accept_s;
    end

    // Record presented to the FIFO and next pending vector
    always_comb begin
        push_s             = drain_push_s & ~clear;
        push_data_s.id     = lowest_idx(pending_r);
        push_data_s.offset = cap_offset_r;
        if (load_s) begin
            pending_next_s = match_in;
        end else if (drain_push_s) begin
            pending_next_s = pending_r & (pending_r - NUM_REPORTS'(1));
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Offset counter, capture register/FSM and drop accounting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= EMPTY;
            pending_r    <= '0;
            offset_r     <= '0;
            cap_offset_r <= '0;
            overflow_r   <= 1'b0;
            drop_count_r <= '0;
        end else if (clear) begin
            state_r      <= EMPTY;
            pending_r    <= '0;
            offset_r     <= '0;
            cap_offset_r <= '0;
            overflow_r   <= 1'b0;
            drop_count_r <= '0;
        end else begin
            if (run) begin
                offset_r <= offset_r + OFFSET_W'(1);
            end
            if (load_s) begin
                cap_offset_r <= offset_r;
            end
            pending_r <= pending_next_s;
            state_r   <= (pending_next_s != '0) ? DRAIN : EMPTY;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) begin
                    drop_count_r <= drop_count_r + 16'd1;
                end
            end
        end
    end

    automata_report_fifo #(
        .rec_t (rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .srst      (clear),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (report_ready),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Decoded from registered state only, so no path from run or match_in
    assign stall         = (state_r == DRAIN) & ~(onehot_s & ~fifo_full_s);
    assign report_valid  = ~fifo_empty_s;
    assign report_id     = fifo_empty_s ? '0 : head_s.id;
    assign report_offset = fifo_empty_s ? '0 : head_s.offset;
    assign overflow      = overflow_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_automata_report_collector.sv
module tb_automata_report_collector;

    localparam int N     = 7;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, clear, run, report_ready;
    logic [N-1:0]  match_in;
    logic          a_stall, a_valid, a_ovf;
    logic [2:0]    a_id;
    logic [31:0]   a_off;
    logic [15:0]   a_drop;
    logic          b_stall, b_valid, b_ovf;
    logic [2:0]    b_id;
    logic [3:0]    b_off;
    logic [15:0]   b_drop;

    automata_report_collector #(.NUM_REPORTS(N), .OFFSET_W(32), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .run(run), .match_in(match_in),
        .stall(a_stall), .report_valid(a_valid), .report_ready(report_ready),
        .report_id(a_id), .report_offset(a_off), .overflow(a_ovf), .drop_count(a_drop));

    automata_report_collector #(.NUM_REPORTS(N), .OFFSET_W(4), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .run(run), .match_in(match_in),
        .stall(b_stall), .report_valid(b_valid), .report_ready(report_ready),
        .report_id(b_id), .report_offset(b_off), .overflow(b_ovf), .drop_count(b_drop));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { int id; logic [31:0] off; } mrec_t;

    // Reference model: records as queue entries, pending rules as an id list
    mrec_t       m_fifo[$];
    int          m_pend[$];
    logic [31:0] m_cap_off;
    logic [31:0] m_off;
    bit          m_ovf;
    int          m_drops;

    mrec_t got_a[$];
    mrec_t got_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_pend.delete();
        m_cap_off = '0;
        m_off     = '0;
        m_ovf     = 1'b0;
        m_drops   = 0;
    endfunction

    function automatic void model_step(input bit c, input bit r, input logic [N-1:0] m, input bit rdy);
        bit full;
        bit accept;
        if (c) begin
            model_reset();
            return;
        end
        full   = (m_fifo.size() == DEPTH);
        accept = (m_pend.size() == 0) || (m_pend.size() == 1 && !full);
        if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (m_pend.size() > 0 && !full) begin
            mrec_t rec;
            rec.id  = m_pend.pop_front();
            rec.off = m_cap_off;
            m_fifo.push_back(rec);
        end
        if (r && m != '0) begin
            if (accept) begin
                for (int i = 0; i < N; i++) if (m[i]) m_pend.push_back(i);
                m_cap_off = m_off;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        if (r) m_off = m_off + 32'd1;
    endfunction

    task automatic check_model(input string tag);
        bit ev;
        bit es;
        ev = (m_fifo.size() > 0);
        es = (m_pend.size() > 0) && !(m_pend.size() == 1 && m_fifo.size() < DEPTH);
        chk($sformatf("%s valid", tag), a_valid, ev);
        chk($sformatf("%s stall", tag), a_stall, es);
        chk($sformatf("%s overflow", tag), a_ovf, m_ovf);
        chk($sformatf("%s drop_count", tag), a_drop, m_drops);
        chk($sformatf("%s b_valid", tag), b_valid, ev);
        chk($sformatf("%s b_stall", tag), b_stall, es);
        if (ev) begin
            chk($sformatf("%s id", tag), a_id, m_fifo[0].id);
            chk($sformatf("%s offset", tag), a_off, m_fifo[0].off);
            chk($sformatf("%s b_id", tag), b_id, m_fifo[0].id);
            chk($sformatf("%s b_offset", tag), b_off, {60'd0, m_fifo[0].off[3:0]});
        end
    endtask

    // One clock: drive inputs, log accepted records, advance model, compare
    task automatic step(input bit c, input bit r, input logic [N-1:0] m, input bit rdy);
        mrec_t rec;
        clear = c; run = r; match_in = m; report_ready = rdy;
        if (a_valid && rdy) begin rec.id = a_id; rec.off = a_off; got_a.push_back(rec); end
        if (b_valid && rdy) begin rec.id = b_id; rec.off = {28'd0, b_off}; got_b.push_back(rec); end
        @(posedge clk);
        model_step(c, r, m, rdy);
        #1;
        check_model("cyc");
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; run = 1'b0; match_in = '0; report_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        got_a.delete();
        got_b.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk($sformatf("%s rst valid", tag), a_valid, 1'b0);
        chk($sformatf("%s rst id", tag), a_id, 3'd0);
        chk($sformatf("%s rst offset", tag), a_off, 32'd0);
        chk($sformatf("%s rst stall", tag), a_stall, 1'b0);
        chk($sformatf("%s rst overflow", tag), a_ovf, 1'b0);
        chk($sformatf("%s rst drop", tag), a_drop, 16'd0);
        chk($sformatf("%s rst b_valid", tag), b_valid, 1'b0);
        chk($sformatf("%s rst b_offset", tag), b_off, 4'd0);
    endtask

    typedef struct {
        bit          run;
        logic [N-1:0] m;
        bit          rdy;
        bit          e_valid;
        int          e_id;
        logic [31:0] e_off;
        bit          e_stall;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [N-1:0] oh;
        logic [N-1:0] m;
        bit r, c, rdy;
        int stall_cycles;

        tbl[0]  = '{1'b1, 7'b0000100, 1'b0, 1'b0, 0, 32'd0, 1'b0};
        tbl[1]  = '{1'b1, 7'b0000000, 1'b0, 1'b1, 2, 32'd0, 1'b0};
        tbl[2]  = '{1'b1, 7'b0000000, 1'b1, 1'b0, 0, 32'd0, 1'b0};
        tbl[3]  = '{1'b1, 7'b0000000, 1'b1, 1'b0, 0, 32'd0, 1'b0};
        tbl[4]  = '{1'b1, 7'b0000000, 1'b1, 1'b0, 0, 32'd0, 1'b0};
        tbl[5]  = '{1'b1, 7'b1010010, 1'b0, 1'b0, 0, 32'd0, 1'b1};
        tbl[6]  = '{1'b0, 7'b0000000, 1'b0, 1'b1, 1, 32'd5, 1'b1};
        tbl[7]  = '{1'b0, 7'b0000000, 1'b0, 1'b1, 1, 32'd5, 1'b0};
        tbl[8]  = '{1'b0, 7'b0000000, 1'b1, 1'b1, 4, 32'd5, 1'b0};
        tbl[9]  = '{1'b0, 7'b0000000, 1'b1, 1'b1, 6, 32'd5, 1'b0};
        tbl[10] = '{1'b0, 7'b0000000, 1'b1, 1'b0, 0, 32'd0, 1'b0};

        // Reset state
        reset = 1'b1; clear = 1'b0; run = 1'b0; match_in = '0; report_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_vals("init");
        reset = 1'b0;
        model_reset();

        // Single-bit and multi-bit vectors from the table
        stall_cycles = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, tbl[i].run, tbl[i].m, tbl[i].rdy);
            chk($sformatf("tbl%0d valid", i), a_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d stall", i), a_stall, tbl[i].e_stall);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d id", i), a_id, tbl[i].e_id);
                chk($sformatf("tbl%0d offset", i), a_off, tbl[i].e_off);
            end
            if (a_stall) stall_cycles++;
        end
        chk("multi stall cycles", stall_cycles, 2);

        // Fill FIFO with ready low, then drop while stalled, then drain
        do_reset();
        for (int i = 0; i < 17; i++) begin
            oh = '0;
            oh[i % N] = 1'b1;
            step(1'b0, 1'b1, oh, 1'b0);
        end
        chk("full stall", a_stall, 1'b1);
        step(1'b0, 1'b1, 7'b0000001, 1'b0);
        chk("drop overflow", a_ovf, 1'b1);
        chk("drop count", a_drop, 16'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("drain count", got_a.size(), 17);
        for (int i = 0; i < got_a.size() && i < 17; i++) begin
            chk($sformatf("drain%0d offset", i), got_a[i].off, i);
            chk($sformatf("drain%0d id", i), got_a[i].id, i % N);
        end

        // Offset wrap on the 4-bit build
        do_reset();
        for (int i = 0; i < 17; i++) begin
            m = (i == 15 || i == 16) ? 7'b0000010 : 7'b0000000;
            step(1'b0, 1'b1, m, 1'b1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("wrap count", got_b.size(), 2);
        if (got_b.size() == 2) begin
            chk("wrap first", got_b[0].off, 32'd15);
            chk("wrap second", got_b[1].off, 32'd0);
        end

        // clear against a load, a pending pop and a set overflow
        do_reset();
        step(1'b0, 1'b1, 7'b0000011, 1'b0);
        chk("clr pre stall", a_stall, 1'b1);
        step(1'b0, 1'b1, 7'b0000001, 1'b0);
        chk("clr pre overflow", a_ovf, 1'b1);
        chk("clr pre valid", a_valid, 1'b1);
        step(1'b1, 1'b1, 7'b1110000, 1'b1);
        chk("clr valid", a_valid, 1'b0);
        chk("clr stall", a_stall, 1'b0);
        chk("clr overflow", a_ovf, 1'b0);
        chk("clr drop", a_drop, 16'd0);
        step(1'b0, 1'b1, 7'b0001000, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("clr next id", a_id, 3'd3);
        chk("clr next offset", a_off, 32'd0);

        // Asynchronous reset in the middle of a 3-bit drain
        do_reset();
        step(1'b0, 1'b1, 7'b0000111, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        #2;
        chk_reset_vals("async");
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("async no stale", a_valid, 1'b0);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 299) == 0);
            if (a_stall) r = ($urandom_range(0, 15) == 0);
            else         r = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0, 1, 2: m = '0;
                3, 4, 5: begin m = '0; m[$urandom_range(0, N - 1)] = 1'b1; end
                default: m = N'($urandom);
            endcase
            if ((i % 400) < 120) rdy = ($urandom_range(0, 7) == 0);
            else                 rdy = ($urandom_range(0, 3) != 0);
            step(c, r, m, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
